fetch_queue_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers returned instructions in a small in-order queue and presents them to decode with valid/ready.
- Branch/jump redirects from EX flush the queue and squash any in-flight response; hazard stalls are applied as backpressure (if_ready low).

---
 rtl/fetch_queue_unit.sv | 126 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one imem request
// in flight, and buffers returned instructions in an in-order queue for decode.
module fetch_queue_unit #(
    parameter int PC_W     = 9,
    parameter int INS_W    = 32,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    input  logic             if_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
    localparam logic [CNT_W:0]   SLOTS   = (CNT_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [PC_W-1:0]  r_fetchPc;
    logic [PC_W-1:0]  r_reqPc;
    logic [PC_W-1:0]  r_qPc    [DEPTH];
    logic [INS_W-1:0] r_qInstr [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_landing;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [CNT_W:0]   w_slotsUsed;

    assign w_landing = imem_rvalid && (r_state != S_IDLE);
    assign w_pop     = if_valid && if_ready && !redirect;
    assign w_push    = imem_rvalid && (r_state == S_WAIT) && !redirect;

    // A kept response still owns its slot the cycle it lands, unless a pop frees one.
    always_comb begin
        w_slotsUsed = {1'b0, r_count};
        if ((r_state == S_WAIT) && !(imem_rvalid && w_pop)) begin
            w_slotsUsed = w_slotsUsed + (CNT_W+1)'(1);
        end
    end

    assign w_issue = !reset && !redirect
                   && ((r_state == S_IDLE) || imem_rvalid)
                   && (w_slotsUsed < SLOTS);

    always_comb begin
        w_stateNext = r_state;
        if (redirect) begin
            if (w_landing) begin
                w_stateNext = S_IDLE;
            end else if (r_state == S_WAIT) begin
                w_stateNext = S_DROP;
            end
        end else if (w_issue) begin
            w_stateNext = S_WAIT;
        end else if (w_landing) begin
            w_stateNext = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Redirect wins over push/pop/issue: the queue is emptied by resetting the pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetchPc <= PC_RST;
            r_reqPc   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_qPc     <= '{default: '0};
            r_qInstr  <= '{default: '0};
        end else if (redirect) begin
            r_fetchPc <= redirect_pc;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            if (w_issue) begin
                r_reqPc   <= r_fetchPc;
                r_fetchPc <= r_fetchPc + PC_W'(4);
            end
            if (w_push) begin
                r_qPc[r_tail]    <= r_reqPc;
                r_qInstr[r_tail] <= imem_rdata;
                r_tail           <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign if_valid  = (r_count != '0);
    assign if_pc     = if_valid ? r_qPc[r_head] : '0;
    assign if_instr  = if_valid ? r_qInstr[r_head] : '0;
    assign imem_req  = w_issue;
    assign imem_addr = r_fetchPc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a variable-latency memory responder, a queue-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_fetch_queue_unit;
    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 2;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic             clk = 1'b0;
    logic             reset;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic [INS_W-1:0] if_instr;
    logic             if_ready;

    int errors = 0;
    int checks = 0;

    fetch_queue_unit #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [PC_W-1:0] a);
        return {7'h55, a, 16'hBEEF};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic red, input logic [PC_W-1:0] rpc,
                                 input logic rdy);
        @(negedge clk);
        redirect    = red;
        redirect_pc = rpc;
        if_ready    = rdy;
        #3;
    endtask

    // Memory: each request seen at a negedge answers memLat cycles later, in order.
    typedef struct { int due; logic [PC_W-1:0] addr; } pend_t;
    pend_t pendQ[$];
    int memLat = 1;
    int cyc = 0;

    initial begin
        pend_t p;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pendQ.size() != 0 && pendQ[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memData(pendQ[0].addr);
                pendQ.delete(0);
            end
            #2;
            if (imem_req === 1'b1) begin
                p.due  = cyc + memLat;
                p.addr = imem_addr;
                pendQ.push_back(p);
            end
        end
    end

    // Reference model: fetch PC, the one outstanding request (none/kept/dropped), and a queue.
    typedef struct { logic [PC_W-1:0] pc; logic [INS_W-1:0] instr; } entry_t;
    entry_t          mQ[$];
    logic [PC_W-1:0] mFetchPc = RESET_PC;
    int              mOut = 0;
    logic [PC_W-1:0] mOutPc = '0;

    function automatic bit modelIssue();
        int used;
        if (reset || redirect) return 1'b0;
        if (mOut != 0 && !imem_rvalid) return 1'b0;
        used = mQ.size();
        if (mOut == 1 && !(imem_rvalid && mQ.size() != 0 && if_ready)) used++;
        return used < DEPTH;
    endfunction

    initial begin
        bit     iss;
        bit     pop;
        entry_t e;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mQ.delete();
                mFetchPc = RESET_PC;
                mOut     = 0;
            end else begin
                iss = modelIssue();
                pop = (mQ.size() != 0) && if_ready && !redirect;
                if (redirect) begin
                    mQ.delete();
                    mFetchPc = redirect_pc;
                    if (mOut != 0) mOut = imem_rvalid ? 0 : 2;
                end else begin
                    if (pop) mQ.delete(0);
                    if (mOut == 1 && imem_rvalid) begin
                        e.pc    = mOutPc;
                        e.instr = imem_rdata;
                        mQ.push_back(e);
                    end
                    if (mOut != 0 && imem_rvalid) mOut = 0;
                    if (iss) begin
                        mOut     = 1;
                        mOutPc   = mFetchPc;
                        mFetchPc = mFetchPc + PC_W'(4);
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-low-phase.
    initial begin
        bit expReq;
        forever begin
            @(negedge clk);
            #3;
            expReq = modelIssue();
            checkOutput("model if_valid", {31'd0, if_valid}, {31'd0, mQ.size() != 0});
            checkOutput("model if_pc", {23'd0, if_pc},
                        {23'd0, (mQ.size() != 0) ? mQ[0].pc : '0});
            checkOutput("model if_instr", if_instr,
                        (mQ.size() != 0) ? mQ[0].instr : '0);
            checkOutput("model imem_req", {31'd0, imem_req}, {31'd0, expReq});
            if (expReq || reset) begin
                checkOutput("model imem_addr", {23'd0, imem_addr}, {23'd0, mFetchPc});
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nValid;
        int nReq;
        logic [PC_W-1:0] lastPc;
        bit lateSeen;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, 1'b1);
        $display("[TB] reset state");
        checkOutput("rst if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst imem_addr", {23'd0, imem_addr}, 32'h000);
        checkOutput("rst if_pc", {23'd0, if_pc}, 32'd0);
        checkOutput("rst if_instr", if_instr, 32'd0);

        $display("[TB] sequential fetch, 1-cycle memory");
        @(negedge clk); reset = 1'b0; #3;
        checkOutput("seq req0", {31'd0, imem_req}, 32'd1);
        checkOutput("seq addr0", {23'd0, imem_addr}, 32'h000);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("seq addr1", {23'd0, imem_addr}, 32'h004);
        checkOutput("seq valid1", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("seq addr2", {23'd0, imem_addr}, 32'h008);
        checkOutput("seq pc0", {23'd0, if_pc}, 32'h000);
        checkOutput("seq instr0", if_instr, memData(9'h000));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("seq pc1", {23'd0, if_pc}, 32'h004);
        checkOutput("seq instr1", if_instr, memData(9'h004));

        $display("[TB] stall for 5 cycles");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("stall pc held", {23'd0, if_pc}, 32'h008);
            checkOutput("stall instr held", if_instr, memData(9'h008));
            checkOutput("stall no req", {31'd0, imem_req}, 32'd0);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain pc0", {23'd0, if_pc}, 32'h008);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain pc1", {23'd0, if_pc}, 32'h00C);
        checkOutput("drain refetch addr", {23'd0, imem_addr}, 32'h010);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain empty", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain pc2", {23'd0, if_pc}, 32'h010);

        $display("[TB] 4-cycle memory latency");
        memLat = 4;
        nValid = 0; nReq = 0; lastPc = '0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (if_valid) begin
                if (nValid > 0) checkOutput("lat4 pc step", {23'd0, if_pc}, {23'd0, lastPc + 9'd4});
                nValid++;
                lastPc = if_pc;
            end
            if (imem_req) nReq++;
        end
        checkOutput("lat4 valid count", nValid, 32'd7);
        checkOutput("lat4 req count", nReq, 32'd6);
        checkOutput("lat4 last pc", {23'd0, lastPc}, 32'h02C);

        $display("[TB] redirect while a request is outstanding");
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre-redirect head", {23'd0, if_pc}, 32'h030);
        applyStimulus(1'b1, 9'h040, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("flush empty", {31'd0, if_valid}, 32'd0);
        checkOutput("drop no req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("after drop req", {31'd0, imem_req}, 32'd1);
        checkOutput("after drop addr", {23'd0, imem_addr}, 32'h040);
        lateSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (if_instr == memData(9'h034)) lateSeen = 1'b1;
            if (if_valid) break;
        end
        checkOutput("redirect valid", {31'd0, if_valid}, 32'd1);
        checkOutput("redirect first pc", {23'd0, if_pc}, 32'h040);
        checkOutput("redirect first instr", if_instr, memData(9'h040));
        checkOutput("late data hidden", {31'd0, lateSeen}, 32'd0);

        $display("[TB] redirect with response and pop in the same cycle");
        memLat = 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (if_valid && imem_rvalid && imem_req) break;
        end
        applyStimulus(1'b1, 9'h100, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("coin empty", {31'd0, if_valid}, 32'd0);
        checkOutput("coin req", {31'd0, imem_req}, 32'd1);
        checkOutput("coin addr", {23'd0, imem_addr}, 32'h100);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("coin empty2", {31'd0, if_valid}, 32'd0);
        checkOutput("coin addr2", {23'd0, imem_addr}, 32'h104);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("coin latency pc", {23'd0, if_pc}, 32'h100);
        checkOutput("coin latency instr", if_instr, memData(9'h100));

        $display("[TB] fetch PC wrap");
        applyStimulus(1'b1, 9'h1F8, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap addr0", {23'd0, imem_addr}, 32'h1F8);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap addr1", {23'd0, imem_addr}, 32'h1FC);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap addr2", {23'd0, imem_addr}, 32'h000);
        checkOutput("wrap pc0", {23'd0, if_pc}, 32'h1F8);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap pc1", {23'd0, if_pc}, 32'h1FC);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wrap pc2", {23'd0, if_pc}, 32'h000);

        $display("[TB] reset pulse during an outstanding request");
        memLat = 3;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("pre-reset valid", {31'd0, if_valid}, 32'd1);
        @(negedge clk); reset = 1'b1; #3;
        checkOutput("mid rst if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("mid rst imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("mid rst imem_addr", {23'd0, imem_addr}, 32'h000);
        @(negedge clk); reset = 1'b0; redirect = 1'b1; redirect_pc = '0; #3;
        checkOutput("post rst no req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b1, '0, 1'b1);
        checkOutput("stray ignored", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post rst req", {31'd0, imem_req}, 32'd1);
        checkOutput("post rst addr", {23'd0, imem_addr}, 32'h000);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stray not queued", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (if_valid) break;
        end
        checkOutput("post rst valid", {31'd0, if_valid}, 32'd1);
        checkOutput("post rst pc", {23'd0, if_pc}, 32'h000);
        checkOutput("post rst instr", if_instr, memData(9'h000));

        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
